// File: rtl/bitblaster_pkg.sv
// ---------------------------------------------------------------------------
// bitblaster_pkg
// Shared definitions for the Bitblaster multi-cycle core:
//   - instruction class codes (instr[DATA_W-1:DATA_W-2])
//   - class-00 function codes (instr[3:0])
//   - FSM state encoding, which is also the externally visible tstep code
//   - flag bit positions inside the {C,N,Z} flags vector
//   - decode helpers shared by the core
// ---------------------------------------------------------------------------
package bitblaster_pkg;

    localparam int CLASS_W = 2;
    localparam int FUNC_W  = 4;
    localparam int TSTEP_W = 3;
    localparam int FLAG_W  = 3;

    // Flag vector layout: flags = {C, N, Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [CLASS_W-1:0] {
        CLS_REG  = 2'b00,
        CLS_BAD  = 2'b01,
        CLS_ADDI = 2'b10,
        CLS_SUBI = 2'b11
    } cls_e;

    typedef enum logic [FUNC_W-1:0] {
        F_LD    = 4'h0,
        F_CP    = 4'h1,
        F_ADD   = 4'h2,
        F_SUB   = 4'h3,
        F_INV   = 4'h4,
        F_FLP   = 4'h5,
        F_AND   = 4'h6,
        F_OR    = 4'h7,
        F_XOR   = 4'h8,
        F_LSL   = 4'h9,
        F_LSR   = 4'hA,
        F_ASR   = 4'hB,
        F_LDM   = 4'hC,
        F_STM   = 4'hD,
        F_RSV_E = 4'hE,
        F_RSV_F = 4'hF
    } func_e;

    // The numeric encoding is the tstep output code.
    typedef enum logic [TSTEP_W-1:0] {
        ST_FETCH = 3'd0,
        ST_T1    = 3'd1,
        ST_T2    = 3'd2,
        ST_T3    = 3'd3,
        ST_MEMW  = 3'd4
    } state_e;

    // Execution shape of a decoded instruction; drives the timestep sequence.
    typedef enum logic [2:0] {
        KIND_ILLEGAL = 3'd0,
        KIND_MOVE    = 3'd1,   // ld, cp        : T1 write
        KIND_UNARY   = 3'd2,   // inv, flp      : T1 G, T2 write
        KIND_BINARY  = 3'd3,   // alu, addi/subi: T1 A, T2 G, T3 write
        KIND_MEM     = 3'd4    // ldm, stm      : T1 request, MEMW wait
    } kind_e;

    function automatic kind_e op_kind(input cls_e cls, input func_e fn);
        kind_e k;
        k = KIND_ILLEGAL;
        if (cls == CLS_ADDI || cls == CLS_SUBI) begin
            k = KIND_BINARY;
        end else if (cls == CLS_REG) begin
            case (fn)
                F_LD, F_CP:         k = KIND_MOVE;
                F_INV, F_FLP:       k = KIND_UNARY;
                F_LDM, F_STM:       k = KIND_MEM;
                F_RSV_E, F_RSV_F:   k = KIND_ILLEGAL;
                default:            k = KIND_BINARY;
            endcase
        end
        return k;
    endfunction

    // Immediate classes reuse the add/sub datapath.
    function automatic func_e alu_func(input cls_e cls, input func_e fn);
        func_e f;
        case (cls)
            CLS_ADDI: f = F_ADD;
            CLS_SUBI: f = F_SUB;
            default:  f = fn;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/bitblaster_if.sv
// ---------------------------------------------------------------------------
// bitblaster_if
// Instruction channel and data-memory channel of the Bitblaster core.
//   master : the core side (accepts instructions, issues memory requests)
//   slave  : the environment side (offers instructions, answers memory)
// Signals:
//   instr_valid/instr_ready/instr  instruction handshake
//   ext_data                        external operand for ld
//   mem_req/mem_we/mem_addr/mem_wdata  registered request, held until ack
//   mem_ack/mem_rdata               completion, read data valid with ack
// ---------------------------------------------------------------------------
interface bitblaster_if #(
    parameter int DATA_W = 10,
    parameter int MEM_AW = 10
);
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] ext_data;

    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  instr_valid, instr, ext_data, mem_ack, mem_rdata,
        output instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output instr_valid, instr, ext_data, mem_ack, mem_rdata,
        input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/bitblaster_alu_p.sv
// ---------------------------------------------------------------------------
// bitblaster_alu_p
// A and G registers, ALU function mux and {C,N,Z} flag generation.
// State updates on the falling edge of clk; rst is asynchronous, active-high.
// Ports:
//   clk, rst      clock (falling edge active) and reset
//   load_a, a_in  capture first operand into A
//   load_g, func  capture func(A, operand) into G and update flags
//   operand       second operand ([Ry] or immediate)
//   g_q, flags_q  G register and flags {C,N,Z}
// ---------------------------------------------------------------------------
module bitblaster_alu_p
    import bitblaster_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_a,
    input  logic [DATA_W-1:0] a_in,
    input  logic              load_g,
    input  func_e             func,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] g_q,
    output logic [FLAG_W-1:0] flags_q
);
    localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] g_reg;
    logic [DATA_W-1:0] g_next;
    logic [FLAG_W-1:0] flags_reg;
    logic [FLAG_W-1:0] flags_next;
    logic              carry_next;
    logic              shift_over;

    always_comb begin
        g_next     = '0;
        carry_next = 1'b0;
        // Shift amount is the full unsigned operand; anything at or above
        // the word width saturates instead of wrapping.
        shift_over = (operand >= SHIFT_LIMIT);
        case (func)
            F_ADD: {carry_next, g_next} = {1'b0, a_reg} + {1'b0, operand};
            F_SUB: begin
                g_next     = a_reg - operand;
                carry_next = (a_reg < operand);   // borrow
            end
            F_INV: g_next = '0 - operand;
            F_FLP: g_next = ~operand;
            F_AND: g_next = a_reg & operand;
            F_OR:  g_next = a_reg | operand;
            F_XOR: g_next = a_reg ^ operand;
            F_LSL: g_next = shift_over ? '0 : (a_reg << operand);
            F_LSR: g_next = shift_over ? '0 : (a_reg >> operand);
            F_ASR: g_next = shift_over ? {DATA_W{a_reg[DATA_W-1]}}
                                       : $unsigned($signed(a_reg) >>> operand);
            default: g_next = '0;
        endcase

        flags_next         = '0;
        flags_next[FLAG_C] = carry_next;
        flags_next[FLAG_N] = g_next[DATA_W-1];
        flags_next[FLAG_Z] = (g_next == '0);
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            g_reg     <= '0;
            flags_reg <= '0;
        end else begin
            if (load_a) begin
                a_reg <= a_in;
            end
            if (load_g) begin
                g_reg     <= g_next;
                flags_reg <= flags_next;
            end
        end
    end

    assign g_q     = g_reg;
    assign flags_q = flags_reg;

endmodule

// File: rtl/bitblaster_core.sv
// ---------------------------------------------------------------------------
// bitblaster_core
// Multi-cycle Bitblaster processor: instruction register, timestep FSM,
// register file, ALU (bitblaster_alu_p) and a data-memory port with a
// variable-latency req/ack handshake.
// All state updates on the falling edge of CLKb; RST is asynchronous,
// active-high and aborts any instruction in flight.
// Parameters: DATA_W >= 2+2*REG_AW+4, NREG = 2**REG_AW, MEM_AW <= DATA_W.
// Ports:
//   CLKb, RST       clock (falling edge active), reset
//   bus             instruction + memory channels (bitblaster_if.master)
//   done, illegal   one-cycle retire / undefined-opcode pulses
//   flags           {C,N,Z}
//   tstep           FSM state code (0 FETCH,1 T1,2 T2,3 T3,4 MEMW)
//   dbg_rda, dbg_q  combinational register peek
// ---------------------------------------------------------------------------
module bitblaster_core
    import bitblaster_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int REG_AW = 2,
    parameter int MEM_AW = 10
) (
    input  logic               CLKb,
    input  logic               RST,
    bitblaster_if.master       bus,
    output logic               done,
    output logic               illegal,
    output logic [FLAG_W-1:0]  flags,
    output logic [TSTEP_W-1:0] tstep,
    input  logic [REG_AW-1:0]  dbg_rda,
    output logic [DATA_W-1:0]  dbg_q
);
    localparam int NREG  = 1 << REG_AW;
    localparam int IMM_W = DATA_W - CLASS_W - REG_AW;

    // ---------------- instruction register and decode ----------------
    logic [DATA_W-1:0] ir_reg;
    cls_e              ir_cls;
    func_e             ir_func;
    kind_e             ir_kind;
    logic [REG_AW-1:0] rx;
    logic [REG_AW-1:0] ry;
    logic [DATA_W-1:0] imm_ext;

    assign ir_cls  = cls_e'(ir_reg[DATA_W-1 -: CLASS_W]);
    assign rx      = ir_reg[DATA_W-CLASS_W-1 -: REG_AW];
    assign ry      = ir_reg[DATA_W-CLASS_W-REG_AW-1 -: REG_AW];
    assign ir_func = func_e'(ir_reg[FUNC_W-1:0]);
    assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, ir_reg[IMM_W-1:0]};
    assign ir_kind = op_kind(ir_cls, ir_func);

    // ---------------- register file ----------------
    logic [DATA_W-1:0] regs_q [NREG];
    logic              reg_we;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] rx_val;
    logic [DATA_W-1:0] ry_val;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic [DATA_W-1:0] q_reg;
            logic              wr_sel;

            assign wr_sel = reg_we && (rx == REG_AW'(gi));

            always_ff @(negedge CLKb or posedge RST) begin
                if (RST) begin
                    q_reg <= '0;
                end else if (wr_sel) begin
                    q_reg <= reg_wdata;
                end
            end

            assign regs_q[gi] = q_reg;
        end
    endgenerate

    assign rx_val = regs_q[rx];
    assign ry_val = regs_q[ry];
    assign dbg_q  = regs_q[dbg_rda];

    // ---------------- ALU ----------------
    logic              load_a;
    logic              load_g;
    logic [DATA_W-1:0] g_q;
    logic [DATA_W-1:0] alu_operand;
    func_e             alu_fn;

    assign alu_fn      = alu_func(ir_cls, ir_func);
    assign alu_operand = (ir_cls == CLS_ADDI || ir_cls == CLS_SUBI) ? imm_ext : ry_val;

    bitblaster_alu_p #(
        .DATA_W (DATA_W)
    ) u_alu (
        .clk     (CLKb),
        .rst     (RST),
        .load_a  (load_a),
        .a_in    (rx_val),
        .load_g  (load_g),
        .func    (alu_fn),
        .operand (alu_operand),
        .g_q     (g_q),
        .flags_q (flags)
    );

    // ---------------- FSM ----------------
    state_e            state_reg;
    state_e            state_next;
    logic              load_ir;
    logic              done_next;
    logic              illegal_next;
    logic              mem_start;
    logic              mem_finish;

    logic              done_reg;
    logic              illegal_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [MEM_AW-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    always_ff @(negedge CLKb or posedge RST) begin
        if (RST) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        load_ir      = 1'b0;
        load_a       = 1'b0;
        load_g       = 1'b0;
        reg_we       = 1'b0;
        reg_wdata    = '0;
        done_next    = 1'b0;
        illegal_next = 1'b0;
        mem_start    = 1'b0;
        mem_finish   = 1'b0;

        case (state_reg)
            ST_FETCH: begin
                if (bus.instr_valid) begin
                    load_ir    = 1'b1;
                    state_next = ST_T1;
                end
            end

            ST_T1: begin
                case (ir_kind)
                    KIND_MOVE: begin
                        reg_we     = 1'b1;
                        reg_wdata  = (ir_func == F_LD) ? bus.ext_data : ry_val;
                        done_next  = 1'b1;
                        state_next = ST_FETCH;
                    end
                    KIND_UNARY: begin
                        load_g     = 1'b1;
                        state_next = ST_T2;
                    end
                    KIND_BINARY: begin
                        load_a     = 1'b1;
                        state_next = ST_T2;
                    end
                    KIND_MEM: begin
                        mem_start  = 1'b1;
                        state_next = ST_MEMW;
                    end
                    default: begin
                        illegal_next = 1'b1;
                        state_next   = ST_FETCH;
                    end
                endcase
            end

            ST_T2: begin
                if (ir_kind == KIND_UNARY) begin
                    reg_we     = 1'b1;
                    reg_wdata  = g_q;
                    done_next  = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    load_g     = 1'b1;
                    state_next = ST_T3;
                end
            end

            ST_T3: begin
                reg_we     = 1'b1;
                reg_wdata  = g_q;
                done_next  = 1'b1;
                state_next = ST_FETCH;
            end

            ST_MEMW: begin
                if (bus.mem_ack) begin
                    mem_finish = 1'b1;
                    done_next  = 1'b1;
                    reg_we     = !mem_we_reg;      // only ldm writes back
                    reg_wdata  = bus.mem_rdata;
                    state_next = ST_FETCH;
                end
            end

            default: state_next = ST_FETCH;
        endcase
    end

    // IR, pulse outputs and the registered memory request.
    always_ff @(negedge CLKb or posedge RST) begin
        if (RST) begin
            ir_reg        <= '0;
            done_reg      <= 1'b0;
            illegal_reg   <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            done_reg    <= done_next;
            illegal_reg <= illegal_next;
            if (load_ir) begin
                ir_reg <= bus.instr;
            end
            // Address, direction and write data are frozen at T1 so they stay
            // stable for the whole wait, however long the memory takes.
            if (mem_start) begin
                mem_req_reg   <= 1'b1;
                mem_we_reg    <= (ir_func == F_STM);
                mem_addr_reg  <= ry_val[MEM_AW-1:0];
                mem_wdata_reg <= rx_val;
            end else if (mem_finish) begin
                mem_req_reg <= 1'b0;
                mem_we_reg  <= 1'b0;
            end
        end
    end

    assign bus.instr_ready = (state_reg == ST_FETCH);
    assign bus.mem_req     = mem_req_reg;
    assign bus.mem_we      = mem_we_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_wdata   = mem_wdata_reg;
    assign done            = done_reg;
    assign illegal         = illegal_reg;
    assign tstep           = state_reg;

endmodule

// File: tb/tb_bitblaster_core.sv
// ---------------------------------------------------------------------------
// tb_bitblaster_core
// Directed test of bitblaster_core. Inputs change and outputs are sampled
// 1 ns after the active (falling) clock edge; a small memory responder
// answers requests on the rising edge after a programmable wait.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bitblaster_core;
    import bitblaster_pkg::*;

    localparam int DW = 10;
    localparam int RA = 2;
    localparam int MA = 10;

    logic          CLKb = 1'b0;
    logic          RST  = 1'b1;
    logic          done;
    logic          illegal;
    logic [2:0]    flags;
    logic [2:0]    tstep;
    logic [RA-1:0] dbg_rda = '0;
    logic [DW-1:0] dbg_q;

    bitblaster_if #(.DATA_W(DW), .MEM_AW(MA)) bus ();

    bitblaster_core #(
        .DATA_W (DW),
        .REG_AW (RA),
        .MEM_AW (MA)
    ) dut (
        .CLKb    (CLKb),
        .RST     (RST),
        .bus     (bus),
        .done    (done),
        .illegal (illegal),
        .flags   (flags),
        .tstep   (tstep),
        .dbg_rda (dbg_rda),
        .dbg_q   (dbg_q)
    );

    always #5 CLKb = ~CLKb;

    // ---------------- memory responder ----------------
    logic [DW-1:0] tb_mem [1<<MA];
    logic          resp_ack   = 1'b0;
    logic          stray_ack  = 1'b0;
    logic [DW-1:0] resp_rdata = '0;
    int            ack_delay  = 0;
    int            wait_cnt   = 0;
    int            req_cycles = 0;
    logic          cap_we     = 1'b0;
    logic [MA-1:0] cap_addr   = '0;
    logic [DW-1:0] cap_wdata  = '0;

    assign bus.mem_ack   = resp_ack | stray_ack;
    assign bus.mem_rdata = resp_rdata;

    always @(posedge CLKb) begin
        if (bus.mem_req) begin
            req_cycles <= req_cycles + 1;
            cap_we     <= bus.mem_we;
            cap_addr   <= bus.mem_addr;
            cap_wdata  <= bus.mem_wdata;
            if (wait_cnt >= ack_delay) begin
                resp_ack <= 1'b1;
                if (bus.mem_we) begin
                    tb_mem[bus.mem_addr] <= bus.mem_wdata;
                    resp_rdata           <= bus.mem_wdata;
                end else begin
                    resp_rdata <= tb_mem[bus.mem_addr];
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            resp_ack <= 1'b0;
            wait_cnt <= 0;
        end
    end

    // ---------------- checking helpers ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input int r, input logic [DW-1:0] exp);
        dbg_rda = RA'(r);
        #1;
        chk(tag, {22'd0, dbg_q}, {22'd0, exp});
    endtask

    function automatic logic [DW-1:0] op(input logic [1:0] rx, input logic [1:0] ry,
                                         input logic [3:0] fn);
        return {2'b00, rx, ry, fn};
    endfunction

    function automatic logic [DW-1:0] opi(input logic [1:0] cls, input logic [1:0] rx,
                                          input logic [5:0] imm);
        return {cls, rx, imm};
    endfunction

    // Issue one instruction from FETCH and count falling edges after the
    // handshake edge until done or illegal is seen (bounded).
    int         lat;
    logic       saw_done;
    logic       saw_ill;
    logic [2:0] t1_code;

    task automatic exec(input logic [DW-1:0] w);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        @(negedge CLKb); #1;
        bus.instr_valid = 1'b0;
        t1_code  = tstep;
        lat      = 0;
        saw_done = 1'b0;
        saw_ill  = 1'b0;
        while (!saw_done && !saw_ill && lat < 40) begin
            @(negedge CLKb); #1;
            lat++;
            saw_done = done;
            saw_ill  = illegal;
        end
    endtask

    task automatic load(input int r, input logic [DW-1:0] v);
        bus.ext_data = v;
        exec(op(RA'(r), 2'd0, 4'h0));
    endtask

    int rc0;

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.ext_data    = '0;

        // ---------------- reset ----------------
        repeat (3) @(negedge CLKb);
        @(posedge CLKb); RST = 1'b0;
        @(negedge CLKb); #1;
        for (int r = 0; r < 4; r++) chk_reg("reset_reg", r, 10'h000);
        chk("reset_ready",   bus.instr_ready, 1);
        chk("reset_flags",   flags, 0);
        chk("reset_mem_req", bus.mem_req, 0);
        chk("reset_mem_we",  bus.mem_we, 0);
        chk("reset_tstep",   tstep, 0);
        chk("reset_done",    done, 0);

        // ---------------- ld / add ----------------
        load(1, 10'h155);
        chk("ld_latency", lat, 1);
        chk("ld_t1_code", t1_code, 1);
        chk_reg("ld_r1", 1, 10'h155);

        exec(op(2'd1, 2'd1, 4'h2));
        chk("add_latency", lat, 3);
        chk("add_done", saw_done, 1);
        chk_reg("add_r1", 1, 10'h2AA);
        chk("add_flags", flags, 3'b010);

        // ---------------- subi / sub ----------------
        load(2, 10'd5);
        exec(opi(2'b11, 2'd2, 6'd6));
        chk("subi_latency", lat, 3);
        chk_reg("subi_r2", 2, 10'h3FF);
        chk("subi_flags", flags, 3'b110);

        exec(op(2'd2, 2'd2, 4'h3));
        chk_reg("sub_self_r2", 2, 10'h000);
        chk("sub_self_flags", flags, 3'b001);

        // ---------------- addi with carry out ----------------
        load(0, 10'h3FF);
        exec(opi(2'b10, 2'd0, 6'd1));
        chk_reg("addi_wrap_r0", 0, 10'h000);
        chk("addi_wrap_flags", flags, 3'b101);

        // ---------------- shifts ----------------
        load(3, 10'd12);
        load(0, 10'h2AA);
        exec(op(2'd0, 2'd3, 4'hA));
        chk_reg("lsr_over_r0", 0, 10'h000);
        chk("lsr_over_flags", flags, 3'b001);

        load(1, 10'h200);
        exec(op(2'd1, 2'd3, 4'hB));
        chk_reg("asr_over_r1", 1, 10'h3FF);
        chk("asr_over_flags", flags, 3'b010);

        load(2, 10'd1);
        load(1, 10'h200);
        exec(op(2'd1, 2'd2, 4'h9));
        chk_reg("lsl_out_r1", 1, 10'h000);
        chk("lsl_out_flags", flags, 3'b001);

        load(0, 10'h155);
        exec(op(2'd0, 2'd2, 4'hA));
        chk_reg("lsr_one_r0", 0, 10'h0AA);
        chk("lsr_one_flags", flags, 3'b000);

        // ---------------- unary ----------------
        exec(op(2'd3, 2'd2, 4'h4));
        chk("inv_latency", lat, 2);
        chk_reg("inv_r3", 3, 10'h3FF);
        chk("inv_flags", flags, 3'b010);

        exec(op(2'd0, 2'd2, 4'h5));
        chk("flp_latency", lat, 2);
        chk_reg("flp_r0", 0, 10'h3FE);

        // ---------------- logic ops and cp ----------------
        load(0, 10'h0F0);
        load(1, 10'h33C);
        exec(op(2'd0, 2'd1, 4'h6));
        chk_reg("and_r0", 0, 10'h030);
        chk("and_flags", flags, 3'b000);
        exec(op(2'd1, 2'd0, 4'h8));
        chk_reg("xor_r1", 1, 10'h30C);
        exec(op(2'd0, 2'd1, 4'h7));
        chk_reg("or_r0", 0, 10'h33C);
        chk("or_flags", flags, 3'b010);
        exec(op(2'd3, 2'd1, 4'h1));
        chk("cp_latency", lat, 1);
        chk_reg("cp_r3", 3, 10'h30C);

        // ---------------- stm with delayed ack ----------------
        load(2, 10'd7);
        load(1, 10'h2AA);
        ack_delay = 3;
        rc0 = req_cycles;
        exec(op(2'd1, 2'd2, 4'hD));
        chk("stm_latency", lat, 5);
        chk("stm_done", saw_done, 1);
        chk("stm_req_cycles", req_cycles - rc0, 4);
        chk("stm_we", cap_we, 1);
        chk("stm_addr", cap_addr, 7);
        chk("stm_wdata", cap_wdata, 10'h2AA);
        chk("stm_req_low", bus.mem_req, 0);

        // stray ack in FETCH
        stray_ack = 1'b1;
        repeat (2) @(negedge CLKb);
        #1;
        chk("stray_tstep", tstep, 0);
        chk("stray_done", done, 0);
        chk("stray_req", bus.mem_req, 0);
        chk_reg("stray_r0", 0, 10'h33C);
        stray_ack = 1'b0;

        // ---------------- ldm with immediate ack ----------------
        ack_delay = 0;
        exec(op(2'd0, 2'd2, 4'hC));
        chk("ldm_latency", lat, 2);
        chk("ldm_we", cap_we, 0);
        chk_reg("ldm_r0", 0, 10'h2AA);

        // ---------------- reset during MEMW ----------------
        ack_delay = 50;
        bus.instr       = op(2'd3, 2'd2, 4'hC);
        bus.instr_valid = 1'b1;
        @(negedge CLKb); #1;
        bus.instr_valid = 1'b0;
        @(negedge CLKb); #1;
        chk("memw_req_high", bus.mem_req, 1);
        chk("memw_tstep", tstep, 4);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_req_drop", bus.mem_req, 0);
        chk("rst_tstep", tstep, 0);
        @(posedge CLKb); RST = 1'b0;
        ack_delay = 0;
        @(negedge CLKb); #1;
        chk("rst_ready", bus.instr_ready, 1);
        chk_reg("rst_r3", 3, 10'h000);

        // ---------------- illegal opcodes ----------------
        load(1, 10'h155);
        exec(10'b01_01_10_0010);
        chk("ill01_pulse", saw_ill, 1);
        chk("ill01_done", saw_done, 0);
        chk("ill01_latency", lat, 1);
        chk_reg("ill01_r1", 1, 10'h155);
        chk("ill01_flags", flags, 0);
        exec(op(2'd1, 2'd1, 4'hE));
        chk("illE_pulse", saw_ill, 1);
        chk_reg("illE_r1", 1, 10'h155);
        @(negedge CLKb); #1;
        chk("ill_pulse_len", illegal, 0);
        chk("ill_tstep", tstep, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
